hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised pipeline hazard unit for the MIPS core, successor to the fixed 5-stage forwarding/stall logic.
- Tracks in-flight register writers in a shift-register scoreboard covering NSTAGE back-end slots (slot 1 = E … slot NSTAGE = W).
- Each writer carries its own result-availability stage, so the block generates per-operand forward selects and decode stalls.
- Also owns a multi-cycle divider busy counter for HI/LO interlocks.

Parameters:
- NSTAGE, 3, number of back-end slots tracked after D (E, M, W)
- AW, 5, register address width; register 0 never causes a hazard
- SW, $clog2(NSTAGE+1), width of slot indices and forward selects
- DIV_LAT, 32, divider busy cycles after issue (>=2)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- d_valid  in  1  valid instruction in D
- d_rs, d_rt  in  AW  D source registers
- d_rs_used, d_rt_used  in  1  operand actually read
- d_wen  in  1  D instruction writes GPR
- d_waddr  in  AW  destination register
- d_avail  in  SW  first slot (1..NSTAGE) at which the result is forwardable; 1 = ALU, 2 = load
- d_hilo_rd, d_hilo_wr  in  1  reads / writes HI/LO (non-divider)
- d_div  in  1  D instruction starts the divider
- be_stall  in  1  back end frozen (memory busy)
- flush_exc  in  1  exception/eret taken at M
- d_stall  out  1  hold F/D, insert bubble into E
- issue  out  1  D instruction accepted into slot 1 this cycle
- fwd_a, fwd_b  out  SW  0 = regfile, k = result of slot k
- div_busy  out  1  divider running
- div_abort  out  1  one-cycle pulse: divider cancelled by flush

Behaviour:
- Reset (async, resetn=0): all slots invalid, div counter 0; d_stall=0, issue=0, fwd_a=fwd_b=0, div_busy=0, div_abort=0.
- Slot contents: {valid, waddr, avail, hilo_wr}. A slot is a writer only if valid && waddr!=0.
- Issue rule: issue = d_valid && !d_stall && !be_stall && !flush_exc.
- Shift on each edge with be_stall=0:
  - slot[k+1] <= slot[k]; slot[NSTAGE] retires.
  - slot[1] <= issue ? {d_wen, d_waddr, d_avail, d_hilo_wr|d_div} : bubble.
- be_stall=1: every slot holds; flush_exc is ignored. The source must keep flush_exc asserted until the back end is released.
- flush_exc=1 with be_stall=0: slots 1..NSTAGE-1 are invalidated in the shift, and slot 1 receives a bubble. The old slot NSTAGE-1 (the excepting M instruction) does not advance into slot NSTAGE. The old W instruction retires normally.
- Operand lookup (combinational, per operand, only when used and reg!=0):
  - Search slots 1..NSTAGE and take the lowest k (youngest) with a matching waddr.
  - k >= slot.avail: fwd = k.
  - k < slot.avail: operand stall.
  - No match: fwd = 0.
  - An older matching writer is never selected when a younger one exists.
- HI/LO stall: d_hilo_rd or d_hilo_wr or d_div, while div_busy=1 or any valid slot in 1..NSTAGE-1 has hilo_wr.
- d_stall = d_valid && (operand stall A || operand stall B || HI/LO stall). It is independent of be_stall and flush_exc.
- Divider counter:
  - On an edge where issue && d_div: load DIV_LAT; div_busy=1 from the next cycle.
  - Counter decrements every cycle, including during be_stall. div_busy = (counter != 0).
  - flush_exc && !be_stall && div_busy: counter cleared to 0 and div_abort pulses 1 cycle. This applies even if the divide instruction has already reached W.
- Simultaneous issue and retire of the same waddr: the newer writer wins.
- Reset mid-divide: counter cleared immediately; no div_abort pulse.

Optional Feature:
- Macro: HAZARD_SB_PERF_EN.
- With the macro defined, the block adds 32-bit wrapping outputs perf_raw_stall, perf_hilo_stall and perf_flush:
  - perf_raw_stall: cycles with d_valid && operand stall.
  - perf_hilo_stall: cycles with HI/LO stall and no operand stall.
  - perf_flush: count of flush_exc edges acted upon.
  - All three reset to 0.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- ALU writer then consumer: issue r5 (avail=1); next cycle D reads rs=r5 -> d_stall=0, fwd_a=1; following cycle -> fwd_a=2; then fwd_a=3; then fwd_a=0.
- Load-use: issue r8 (avail=2); next cycle D reads rt=r8 -> d_stall=1, issue=0, bubble in slot 1; next cycle -> d_stall=0, fwd_b=2.
- Youngest wins: r3 in slot 3 and r3 in slot 1 (avail=1) -> fwd_a=1. Reading r0 with slots all writing r0 -> fwd_a=0, d_stall=0.
- be_stall: hold 4 cycles with a writer in slot 2 -> fwd stays 2 and slots unchanged; flush_exc asserted during hold is ignored until release, then slots 1..2 cleared.
- Divider: issue d_div with DIV_LAT=32 -> div_busy=1 for exactly 32 cycles; mfhi in D stalls for that window; flush_exc at cycle 10 -> div_busy=0 and div_abort=1 for one cycle.
- Async reset asserted mid-divide with 3 valid slots -> outputs zero immediately; after release a read of a previously pending register gives fwd=0, d_stall=0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage request and hazard responses exchanged with hazard_scoreboard.
// Perf counter outputs exist only when HAZARD_SB_PERF_EN is defined.
interface hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int SW = 2
);
  logic          d_valid;
  logic [AW-1:0] d_rs;
  logic [AW-1:0] d_rt;
  logic          d_rs_used;
  logic          d_rt_used;
  logic          d_wen;
  logic [AW-1:0] d_waddr;
  logic [SW-1:0] d_avail;
  logic          d_hilo_rd;
  logic          d_hilo_wr;
  logic          d_div;
  logic          be_stall;
  logic          flush_exc;
  logic          d_stall;
  logic          issue;
  logic [SW-1:0] fwd_a;
  logic [SW-1:0] fwd_b;
  logic          div_busy;
  logic          div_abort;
`ifdef HAZARD_SB_PERF_EN
  logic [31:0]   perf_raw_stall;
  logic [31:0]   perf_hilo_stall;
  logic [31:0]   perf_flush;
`endif

  modport master (
    output d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_wen, d_waddr, d_avail,
    output d_hilo_rd, d_hilo_wr, d_div, be_stall, flush_exc,
    input  d_stall, issue, fwd_a, fwd_b, div_busy, div_abort
`ifdef HAZARD_SB_PERF_EN
    ,
    input  perf_raw_stall, perf_hilo_stall, perf_flush
`endif
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_wen, d_waddr, d_avail,
    input  d_hilo_rd, d_hilo_wr, d_div, be_stall, flush_exc,
    output d_stall, issue, fwd_a, fwd_b, div_busy, div_abort
`ifdef HAZARD_SB_PERF_EN
    ,
    output perf_raw_stall, perf_hilo_stall, perf_flush
`endif
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Parametrised hazard scoreboard: per-operand forward selects, decode stalls, divider HI/LO interlock.
// Lookup is combinational; slots/counter update each edge, be_stall freezes slots. Perf counters: HAZARD_SB_PERF_EN.
module hazard_scoreboard #(
  parameter int NSTAGE  = 3,
  parameter int AW      = 5,
  parameter int SW      = $clog2(NSTAGE + 1),
  parameter int DIV_LAT = 32
) (
  input logic                clk,
  input logic                resetn,
  hazard_scoreboard_if.slave sb
);
  localparam int CW = $clog2(DIV_LAT + 1);

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [SW-1:0] avail;
    logic          hilo_wr;
  } slot_t;

  slot_t         slots [1:NSTAGE];
  logic [CW-1:0] div_cnt;
  logic          div_abort_q;
  logic          div_busy;
  logic          stall_a;
  logic          stall_b;
  logic [SW-1:0] fwd_a;
  logic [SW-1:0] fwd_b;
  logic          hilo_pend;
  logic          hilo_stall;
  logic          d_stall;
  logic          issue;
  logic          flush_go;

  // Scan oldest to youngest so the youngest matching writer decides last.
  always_comb begin
    fwd_a   = '0;
    stall_a = 1'b0;
    fwd_b   = '0;
    stall_b = 1'b0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (slots[k].valid && slots[k].wen && (slots[k].waddr != '0)) begin
        if (sb.d_rs_used && (slots[k].waddr == sb.d_rs)) begin
          if (SW'(k) >= slots[k].avail) begin
            fwd_a   = SW'(k);
            stall_a = 1'b0;
          end else begin
            fwd_a   = '0;
            stall_a = 1'b1;
          end
        end
        if (sb.d_rt_used && (slots[k].waddr == sb.d_rt)) begin
          if (SW'(k) >= slots[k].avail) begin
            fwd_b   = SW'(k);
            stall_b = 1'b0;
          end else begin
            fwd_b   = '0;
            stall_b = 1'b1;
          end
        end
      end
    end
  end

  // The W slot has already committed HI/LO, so only slots before it interlock.
  always_comb begin
    hilo_pend = 1'b0;
    for (int k = 1; k < NSTAGE; k++) begin
      if (slots[k].valid && slots[k].hilo_wr) begin
        hilo_pend = 1'b1;
      end
    end
  end

  assign div_busy   = (div_cnt != '0);
  assign hilo_stall = (sb.d_hilo_rd || sb.d_hilo_wr || sb.d_div) && (div_busy || hilo_pend);
  assign d_stall    = sb.d_valid && (stall_a || stall_b || hilo_stall);
  assign issue      = resetn && sb.d_valid && !d_stall && !sb.be_stall && !sb.flush_exc;
  assign flush_go   = sb.flush_exc && !sb.be_stall;

  // A flush empties everything up to M and blocks M from reaching W, so all slots end up empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        slots[k] <= '0;
      end
    end else if (!sb.be_stall) begin
      for (int k = NSTAGE; k >= 2; k--) begin
        slots[k] <= sb.flush_exc ? '0 : slots[k-1];
      end
      if (issue) begin
        slots[1] <= '{valid:   1'b1,
                      wen:     sb.d_wen,
                      waddr:   sb.d_waddr,
                      avail:   sb.d_avail,
                      hilo_wr: sb.d_hilo_wr || sb.d_div};
      end else begin
        slots[1] <= '0;
      end
    end
  end

  // The divider keeps counting through back-end stalls; only an acted-upon flush cancels it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt     <= '0;
      div_abort_q <= 1'b0;
    end else begin
      div_abort_q <= 1'b0;
      if (flush_go && div_busy) begin
        div_cnt     <= '0;
        div_abort_q <= 1'b1;
      end else if (issue && sb.d_div) begin
        div_cnt <= CW'(DIV_LAT);
      end else if (div_busy) begin
        div_cnt <= div_cnt - CW'(1);
      end
    end
  end

  assign sb.d_stall   = d_stall;
  assign sb.issue     = issue;
  assign sb.fwd_a     = fwd_a;
  assign sb.fwd_b     = fwd_b;
  assign sb.div_busy  = div_busy;
  assign sb.div_abort = div_abort_q;

`ifdef HAZARD_SB_PERF_EN
  logic [31:0] raw_cnt;
  logic [31:0] hilo_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raw_cnt   <= '0;
      hilo_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (sb.d_valid && (stall_a || stall_b)) begin
        raw_cnt <= raw_cnt + 32'd1;
      end
      if (sb.d_valid && hilo_stall && !(stall_a || stall_b)) begin
        hilo_cnt <= hilo_cnt + 32'd1;
      end
      if (flush_go) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign sb.perf_raw_stall  = raw_cnt;
  assign sb.perf_hilo_stall = hilo_cnt;
  assign sb.perf_flush      = flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against an in-flight list model.
module tb_hazard_scoreboard;
  localparam int NSTAGE  = 3;
  localparam int AW      = 5;
  localparam int SW      = 2;
  localparam int DIV_LAT = 32;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.AW(AW), .SW(SW)) sb_if ();

  hazard_scoreboard #(
    .NSTAGE (NSTAGE),
    .AW     (AW),
    .SW     (SW),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .sb    (sb_if)
  );

  // Each in-flight instruction remembers how many back-end slots it has advanced.
  typedef struct {
    int pos;
    bit wen;
    int waddr;
    int avail;
    bit hilo;
  } ent_t;

  ent_t inflight[$];
  int   div_rem;
  bit   abort_exp;
  int   n_tests;
  int   n_fail;
  bit   exp_stall;
  bit   exp_issue;
  bit   op_stall_a;
  bit   op_stall_b;
  int   exp_fwd_a;
  int   exp_fwd_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic lookup(input int r, input bit used, output int fwd, output bit stall);
    int best;
    int bav;
    best  = 0;
    bav   = 0;
    fwd   = 0;
    stall = 1'b0;
    if (used && r != 0) begin
      foreach (inflight[i]) begin
        if (inflight[i].wen && inflight[i].waddr == r && (best == 0 || inflight[i].pos < best)) begin
          best = inflight[i].pos;
          bav  = inflight[i].avail;
        end
      end
      if (best != 0) begin
        if (best >= bav) fwd = best;
        else stall = 1'b1;
      end
    end
  endtask

  task automatic predict();
    bit hpend;
    bit hst;
    lookup(int'(sb_if.d_rs), sb_if.d_rs_used, exp_fwd_a, op_stall_a);
    lookup(int'(sb_if.d_rt), sb_if.d_rt_used, exp_fwd_b, op_stall_b);
    hpend = 1'b0;
    foreach (inflight[i]) if (inflight[i].pos <= NSTAGE - 1 && inflight[i].hilo) hpend = 1'b1;
    hst       = (sb_if.d_hilo_rd || sb_if.d_hilo_wr || sb_if.d_div) && (div_rem > 0 || hpend);
    exp_stall = sb_if.d_valid && (op_stall_a || op_stall_b || hst);
    exp_issue = sb_if.d_valid && !exp_stall && !sb_if.be_stall && !sb_if.flush_exc;
  endtask

  task automatic model_edge();
    bit   ab;
    ent_t nq[$];
    ent_t e;
    ab = sb_if.flush_exc && !sb_if.be_stall && div_rem > 0;
    if (ab) div_rem = 0;
    else if (exp_issue && sb_if.d_div) div_rem = DIV_LAT;
    else if (div_rem > 0) div_rem--;
    abort_exp = ab;
    if (!sb_if.be_stall) begin
      foreach (inflight[i]) begin
        e = inflight[i];
        if (!(sb_if.flush_exc && e.pos <= NSTAGE - 1)) begin
          e.pos++;
          if (e.pos <= NSTAGE) nq.push_back(e);
        end
      end
      if (exp_issue) begin
        e.pos   = 1;
        e.wen   = sb_if.d_wen;
        e.waddr = int'(sb_if.d_waddr);
        e.avail = int'(sb_if.d_avail);
        e.hilo  = sb_if.d_hilo_wr || sb_if.d_div;
        nq.push_back(e);
      end
      inflight = nq;
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    div_rem   = 0;
    abort_exp = 1'b0;
  endtask

  task automatic eval();
    #1;
    predict();
    check("d_stall", sb_if.d_stall, exp_stall);
    check("issue", sb_if.issue, exp_issue);
    check("div_busy", sb_if.div_busy, div_rem > 0);
    check("div_abort", sb_if.div_abort, abort_exp);
    if (!op_stall_a) check("fwd_a", sb_if.fwd_a, exp_fwd_a);
    if (!op_stall_b) check("fwd_b", sb_if.fwd_b, exp_fwd_b);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cycle();
    eval();
    advance();
  endtask

  task automatic idle();
    sb_if.d_valid   = 1'b0;
    sb_if.d_rs      = '0;
    sb_if.d_rt      = '0;
    sb_if.d_rs_used = 1'b0;
    sb_if.d_rt_used = 1'b0;
    sb_if.d_wen     = 1'b0;
    sb_if.d_waddr   = '0;
    sb_if.d_avail   = 2'd1;
    sb_if.d_hilo_rd = 1'b0;
    sb_if.d_hilo_wr = 1'b0;
    sb_if.d_div     = 1'b0;
    sb_if.be_stall  = 1'b0;
    sb_if.flush_exc = 1'b0;
  endtask

  task automatic write_reg(input int r, input int av);
    idle();
    sb_if.d_valid = 1'b1;
    sb_if.d_wen   = 1'b1;
    sb_if.d_waddr = AW'(r);
    sb_if.d_avail = SW'(av);
  endtask

  task automatic read_regs(input int rs, input bit rs_u, input int rt, input bit rt_u);
    idle();
    sb_if.d_valid   = 1'b1;
    sb_if.d_rs      = AW'(rs);
    sb_if.d_rs_used = rs_u;
    sb_if.d_rt      = AW'(rt);
    sb_if.d_rt_used = rt_u;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < NSTAGE; i++) cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".d_stall"}, sb_if.d_stall, 0);
    check({tag, ".issue"}, sb_if.issue, 0);
    check({tag, ".fwd_a"}, sb_if.fwd_a, 0);
    check({tag, ".fwd_b"}, sb_if.fwd_b, 0);
    check({tag, ".div_busy"}, sb_if.div_busy, 0);
    check({tag, ".div_abort"}, sb_if.div_abort, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  busy_cnt;
    bit  done;
    bit  hold_flush;
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    idle();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    // ALU writer followed by a consumer that walks the forward select E->M->W->regfile
    write_reg(5, 1); cycle();
    for (int i = 1; i <= NSTAGE + 1; i++) begin
      read_regs(5, 1'b1, 0, 1'b0);
      eval();
      check("alu_stall", sb_if.d_stall, 0);
      check("alu_fwd_seq", sb_if.fwd_a, (i <= NSTAGE) ? i : 0);
      advance();
    end

    // load-use: one stall then forward from M
    write_reg(8, 2); cycle();
    read_regs(0, 1'b0, 8, 1'b1);
    eval();
    check("lu_stall", sb_if.d_stall, 1);
    check("lu_noissue", sb_if.issue, 0);
    advance();
    eval();
    check("lu_release", sb_if.d_stall, 0);
    check("lu_fwd_b", sb_if.fwd_b, 2);
    advance();

    // youngest writer wins; r0 never hazards
    write_reg(3, 1); cycle();
    write_reg(9, 1); cycle();
    write_reg(3, 1); cycle();
    read_regs(3, 1'b1, 9, 1'b1);
    eval();
    check("young_fwd_a", sb_if.fwd_a, 1);
    check("young_fwd_b", sb_if.fwd_b, 2);
    advance();
    for (int i = 0; i < NSTAGE; i++) begin write_reg(0, 2); cycle(); end
    read_regs(0, 1'b1, 0, 1'b1);
    eval();
    check("r0_fwd_a", sb_if.fwd_a, 0);
    check("r0_stall", sb_if.d_stall, 0);
    advance();

    // be_stall freezes slots and masks flush until release
    drain();
    write_reg(12, 1); cycle();
    idle(); cycle();
    read_regs(12, 1'b1, 0, 1'b0);
    sb_if.be_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_if.flush_exc = (i >= 2);
      eval();
      check("bes_fwd_hold", sb_if.fwd_a, 2);
      check("bes_noissue", sb_if.issue, 0);
      advance();
    end
    sb_if.be_stall = 1'b0;
    eval();
    check("bes_release_fwd", sb_if.fwd_a, 2);
    advance();
    sb_if.flush_exc = 1'b0;
    eval();
    check("flush_cleared", sb_if.fwd_a, 0);
    advance();

    // divider busy window with mfhi held in D
    drain();
    idle();
    sb_if.d_valid = 1'b1; sb_if.d_div = 1'b1; sb_if.d_wen = 1'b1;
    eval();
    check("div_issue", sb_if.issue, 1);
    advance();
    read_regs(0, 1'b0, 0, 1'b0);
    sb_if.d_hilo_rd = 1'b1;
    busy_cnt = 0;
    done     = 1'b0;
    for (int i = 0; i < 3 * DIV_LAT && !done; i++) begin
      eval();
      if (sb_if.div_busy) begin
        busy_cnt++;
        check("mfhi_stall", sb_if.d_stall, 1);
        advance();
      end else begin
        done = 1'b1;
      end
    end
    check("div_busy_len", busy_cnt, DIV_LAT);
    check("mfhi_go", sb_if.d_stall, 0);
    advance();

    // flush at cycle 10 of a divide aborts it
    idle();
    sb_if.d_valid = 1'b1; sb_if.d_div = 1'b1; sb_if.d_wen = 1'b1;
    cycle();
    idle();
    for (int i = 1; i < 10; i++) cycle();
    sb_if.flush_exc = 1'b1;
    eval();
    check("abort_pre_busy", sb_if.div_busy, 1);
    advance();
    sb_if.flush_exc = 1'b0;
    eval();
    check("abort_busy", sb_if.div_busy, 0);
    check("abort_pulse", sb_if.div_abort, 1);
    advance();
    eval();
    check("abort_once", sb_if.div_abort, 0);
    advance();

    // async reset mid-divide with three valid writers
    idle();
    sb_if.d_valid = 1'b1; sb_if.d_div = 1'b1; sb_if.d_wen = 1'b1;
    cycle();
    write_reg(4, 2); cycle();
    write_reg(6, 3); cycle();
    write_reg(7, 1); cycle();
    read_regs(6, 1'b1, 7, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all_zero("rst_mid");
    @(negedge clk);
    resetn = 1'b1;
    eval();
    check("rst_after_fwd", sb_if.fwd_a, 0);
    check("rst_after_stall", sb_if.d_stall, 0);
    advance();

    // random traffic against the model
    hold_flush = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      sb_if.d_valid   = ($urandom_range(0, 3) != 0);
      sb_if.d_rs      = AW'($urandom_range(0, 7));
      sb_if.d_rt      = AW'($urandom_range(0, 7));
      sb_if.d_rs_used = 1'($urandom_range(0, 1));
      sb_if.d_rt_used = 1'($urandom_range(0, 1));
      sb_if.d_waddr   = AW'($urandom_range(0, 7));
      sb_if.d_avail   = SW'($urandom_range(1, 3));
      sb_if.d_hilo_rd = ($urandom_range(0, 7) == 0);
      sb_if.d_hilo_wr = ($urandom_range(0, 15) == 0);
      sb_if.d_div     = ($urandom_range(0, 15) == 0);
      sb_if.d_wen     = (sb_if.d_hilo_wr || sb_if.d_div) ? 1'b1 : 1'($urandom_range(0, 1));
      sb_if.be_stall  = ($urandom_range(0, 5) == 0);
      sb_if.flush_exc = hold_flush || ($urandom_range(0, 24) == 0);
      hold_flush      = sb_if.flush_exc && sb_if.be_stall;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
